// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared SPI defines: state encodings and idle filler byte
package spi_target_pkg;

    localparam logic [7:0] SPI_IDLE_BYTE_DEFAULT = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_target_sync_edge.sv
// rtl/spi_target_sync_edge.sv - multi-stage synchronizer with rise/fall pulse outputs
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with RX/TX byte registers and sticky error flags
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       clr_flags
);

    spi_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [6:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       hold_q, hold_d;
    logic             tx_ready_q, tx_ready_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_s;
    logic reload, consume, rx_done, overrun_set, underrun_set;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI uses the same depth as SCLK so the sampled bit lines up with the rise pulse
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        hold_d       = hold_q;
        tx_ready_d   = tx_ready_q;
        reload       = 1'b0;
        consume      = 1'b0;
        rx_done      = 1'b0;
        overrun_set  = 1'b0;
        underrun_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 3'd0;
                    reload  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    cnt_d      = cnt_q + 3'd1;
                    rx_done    = (cnt_q == 3'd7);
                end else if (sclk_fall) begin
                    if (cnt_q == 3'd0) begin
                        reload = 1'b1;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b1};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            if (!tx_ready_q) begin
                shift_d = hold_q;
                consume = 1'b1;
            end else begin
                shift_d      = IDLE_BYTE;
                underrun_set = 1'b1;
            end
        end

        if (consume) begin
            tx_ready_d = 1'b1;
        end
        // A load landing on the consume cycle refills the just-emptied holding register
        if (tx_load && (tx_ready_q || consume)) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end

        if (rx_done) begin
            rx_data_d   = {rx_shift_q, mosi_s};
            rx_valid_d  = 1'b1;
            overrun_set = rx_valid_q && !rx_ack;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        overrun_d  = overrun_set  | (overrun_q  & ~clr_flags);
        underrun_d = underrun_set | (underrun_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= IDLE_BYTE;
            rx_shift_q  <= 7'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            hold_q      <= 8'h00;
            tx_ready_q  <= 1'b1;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            mosi_sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            tx_ready_q  <= tx_ready_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign spi_miso    = shift_q[7];
    assign spi_miso_oe = (state_q == ST_ACTIVE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_ready_q;
    assign rx_overrun  = overrun_q;
    assign tx_underrun = underrun_q;

endmodule
